// File: rtl/csr_pkg.sv
// csr_pkg: LoongArch CSR numbers, field positions, writable masks and the masked-write helper
package csr_pkg;
  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0c;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;
  localparam int PLV = 0;
  localparam int IE = 2;
  localparam int DA = 3;
  localparam int PPLV = 0;
  localparam int PIE = 2;
  localparam int LIE = 0;
  localparam int IS = 0;
  localparam int ECODE = 16;
  localparam int ESUBCODE = 22;
  localparam int VA = 0;
  localparam int TCFG_EN = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TI_BIT = 11;
  localparam logic [12:0] ECFG_WMASK = 13'h1bff;
  function automatic logic [31:0] mwr(input logic [31:0] old, input logic [31:0] wdata, input logic [31:0] wmask);
    return (wdata & wmask) | (old & ~wmask);
  endfunction
endpackage

// File: rtl/csr_timer_core.sv
// csr_timer_core: TCFG/TVAL countdown and TI flag (clk, resetn, tcfg_we, ti_clr, wdata/wmask in; tcfg, tval, ti out)
module csr_timer_core import csr_pkg::*; #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tcfg_we,
  input  logic               ti_clr,
  input  logic [TIMER_W-1:0] wdata,
  input  logic [TIMER_W-1:0] wmask,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               ti
);
  logic [TIMER_W-1:0] tcfg_new, reload;
  logic fire;
  always_comb begin
    tcfg_new = (wdata & wmask) | (tcfg & ~wmask);
    reload = {tcfg[TIMER_W-1:2], 2'b00};
    fire = tcfg[TCFG_EN] && !tcfg_we && tval == '0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      tcfg <= '0;
      tval <= '0;
      ti <= 1'b0;
    end else begin
      if (tcfg_we) begin
        tcfg <= tcfg_new;
        tval <= {tcfg_new[TIMER_W-1:2], 2'b00};
      end else if (tcfg[TCFG_EN]) begin
        if (tval != '0) tval <= tval - TIMER_W'(1);
        else if (tcfg[TCFG_PERIODIC]) tval <= reload;
        else tcfg[TCFG_EN] <= 1'b0;
      end
      ti <= fire | (ti & ~ti_clr);
    end
endmodule

// File: rtl/csr_timer_unit.sv
// csr_timer_unit: CSR file (mode, exception, SAVE, timer, stable counter); EX read port, WB write/ex/ertn, entry PCs, interrupt request
module csr_timer_unit import csr_pkg::*; #(
  parameter int          SAVE_NUM = 4,
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] TID_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  input  logic        csr_re,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rdata,
  input  logic        csr_we,
  input  logic [13:0] csr_wnum,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wdata,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic        wb_badv_we,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  output logic [31:0] ex_entry,
  output logic [31:0] er_entry,
  output logic        has_int,
  output logic [63:0] cnt_value,
  output logic [31:0] cnt_id
);
  logic [1:0] plv, pplv, is_sw;
  logic ie, pie, ipi, ti;
  logic [7:0] is_hw;
  logic [12:0] lie, is_all;
  logic [5:0] ecode;
  logic [8:0] esubcode;
  logic [25:0] eentry;
  logic [31:0] era, badv, tid, wbits, rdata;
  logic [31:0] save [16];
  logic [TIMER_W-1:0] tcfg, tval;
  logic we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_badv, we_eentry, we_tid, we_tcfg, we_ticlr;
  logic we_save, rsave_hit;
  always_comb begin
    wbits = csr_wdata & csr_wmask;
    we_crmd = csr_we && csr_wnum == CSR_CRMD;
    we_prmd = csr_we && csr_wnum == CSR_PRMD;
    we_ecfg = csr_we && csr_wnum == CSR_ECFG;
    we_estat = csr_we && csr_wnum == CSR_ESTAT;
    we_era = csr_we && csr_wnum == CSR_ERA;
    we_badv = csr_we && csr_wnum == CSR_BADV;
    we_eentry = csr_we && csr_wnum == CSR_EENTRY;
    we_tid = csr_we && csr_wnum == CSR_TID;
    we_tcfg = csr_we && csr_wnum == CSR_TCFG;
    we_ticlr = csr_we && csr_wnum == CSR_TICLR;
    we_save = csr_we && csr_wnum[13:4] == CSR_SAVE0[13:4] && 32'(csr_wnum[3:0]) < SAVE_NUM;
    rsave_hit = csr_rnum[13:4] == CSR_SAVE0[13:4] && 32'(csr_rnum[3:0]) < SAVE_NUM;
    is_all = {ipi, ti, 1'b0, is_hw, is_sw};
  end
  always_comb begin
    rdata = '0;
    case (csr_rnum)
      CSR_CRMD:   rdata = {28'b0, 1'b1, ie, plv};
      CSR_PRMD:   rdata = {29'b0, pie, pplv};
      CSR_ECFG:   rdata = {19'b0, lie};
      CSR_ESTAT:  rdata = {1'b0, esubcode, ecode, 3'b0, is_all};
      CSR_ERA:    rdata = era;
      CSR_BADV:   rdata = badv;
      CSR_EENTRY: rdata = {eentry, 6'b0};
      CSR_TID:    rdata = tid;
      CSR_TCFG:   rdata = 32'(tcfg);
      CSR_TVAL:   rdata = 32'(tval);
      default:    rdata = rsave_hit ? save[csr_rnum[3:0]] : '0;
    endcase
  end
  assign csr_rdata = csr_re ? rdata : '0;
  assign ex_entry = {eentry, 6'b0};
  assign er_entry = era;
  assign cnt_id = tid;
  assign has_int = |(is_all & lie) & ie;
  csr_timer_core #(.TIMER_W(TIMER_W)) u_timer (
    .clk,
    .resetn,
    .tcfg_we(we_tcfg),
    .ti_clr(we_ticlr & wbits[0]),
    .wdata(csr_wdata[TIMER_W-1:0]),
    .wmask(csr_wmask[TIMER_W-1:0]),
    .tcfg,
    .tval,
    .ti
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      {plv, ie, pplv, pie} <= '0;
      {lie, is_sw, is_hw, ipi, ecode, esubcode} <= '0;
      {badv, eentry} <= '0;
      tid <= TID_RST;
      cnt_value <= '0;
    end else begin
      is_hw <= hw_int_in;
      ipi <= ipi_int_in;
      cnt_value <= cnt_value + 64'd1;
      if (wb_ex) begin
        {pie, pplv} <= {ie, plv};
        {ie, plv} <= 3'b000;
        ecode <= wb_ecode;
        esubcode <= wb_esubcode;
      end else if (ertn_flush) begin
        {ie, plv} <= {pie, pplv};
      end else begin
        if (we_crmd) {ie, plv} <= wbits[2:0] | ({ie, plv} & ~csr_wmask[2:0]);
        if (we_prmd) {pie, pplv} <= wbits[2:0] | ({pie, pplv} & ~csr_wmask[2:0]);
      end
      if (we_ecfg) lie <= (wbits[12:0] | (lie & ~csr_wmask[12:0])) & ECFG_WMASK;
      if (we_estat) is_sw <= wbits[1:0] | (is_sw & ~csr_wmask[1:0]);
      if (wb_ex && wb_badv_we) badv <= wb_vaddr;
      else if (we_badv) badv <= mwr(badv, csr_wdata, csr_wmask);
      if (we_eentry) eentry <= wbits[31:6] | (eentry & ~csr_wmask[31:6]);
      if (we_tid) tid <= mwr(tid, csr_wdata, csr_wmask);
    end
  // ERA and SAVE carry no reset so they map onto plain enable flops
  always_ff @(posedge clk) begin
    if (wb_ex) era <= wb_pc;
    else if (we_era) era <= mwr(era, csr_wdata, csr_wmask);
    for (int i = 0; i < 16; i++)
      if (we_save && csr_wnum[3:0] == 4'(i)) save[i] <= mwr(save[i], csr_wdata, csr_wmask);
  end
endmodule

// File: tb/tb_csr_timer_unit.sv
// tb_csr_timer_unit: directed scoreboard bench for csr_timer_unit with SAVE_NUM=8, TIMER_W=12
module tb_csr_timer_unit;
  localparam logic [13:0] CRMD = 14'h00, PRMD = 14'h01, ECFG = 14'h04, ESTAT = 14'h05, ERA = 14'h06;
  localparam logic [13:0] BADV = 14'h07, EENTRY = 14'h0c, TID = 14'h40, TCFG = 14'h41, TVAL = 14'h42, TICLR = 14'h44;
  localparam logic [31:0] ONES = 32'hffff_ffff;
  logic clk = 1'b0, resetn = 1'b1;
  logic [7:0] hw_int_in;
  logic ipi_int_in, csr_re, csr_we, wb_ex, wb_badv_we, ertn_flush, has_int;
  logic [13:0] csr_rnum, csr_wnum;
  logic [31:0] csr_rdata, csr_wmask, csr_wdata, wb_pc, wb_vaddr, ex_entry, er_entry, cnt_id;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic [63:0] cnt_value;
  logic [63:0] exp_q[$];
  int compared = 0, mismatched = 0;
  always #500 clk = ~clk;
  csr_timer_unit #(.SAVE_NUM(8), .TIMER_W(12), .TID_RST(32'h0000_005a)) dut (
    .clk(clk), .resetn(resetn), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .csr_re(csr_re), .csr_rnum(csr_rnum), .csr_rdata(csr_rdata),
    .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_badv_we(wb_badv_we), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .ex_entry(ex_entry), .er_entry(er_entry), .has_int(has_int),
    .cnt_value(cnt_value), .cnt_id(cnt_id)
  );
  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    e = exp_q.pop_front();
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask
  task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] e);
    exp_q.push_back(e);
    chk(tag, obs);
  endtask
  task automatic rd(input logic [13:0] n, input logic [31:0] e, input string tag);
    exp_q.push_back(64'(e));
    csr_re = 1'b1;
    csr_rnum = n;
    #1;
    chk(tag, 64'(csr_rdata));
    csr_re = 1'b0;
  endtask
  task automatic wr(input logic [13:0] n, input logic [31:0] d, input logic [31:0] m);
    csr_we = 1'b1;
    csr_wnum = n;
    csr_wdata = d;
    csr_wmask = m;
    @(negedge clk);
    csr_we = 1'b0;
    csr_wmask = '0;
  endtask
  initial begin
    {csr_re, csr_we, wb_ex, wb_badv_we, ertn_flush, ipi_int_in} = '0;
    hw_int_in = '0;
    {csr_rnum, csr_wnum} = '0;
    {csr_wmask, csr_wdata, wb_pc, wb_vaddr} = '0;
    wb_ecode = '0;
    wb_esubcode = '0;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    rd(CRMD, 32'h8, "rst_crmd");
    rd(ESTAT, 32'h0, "rst_estat");
    rd(TCFG, 32'h0, "rst_tcfg");
    ck("rst_has_int", 64'(has_int), 64'h0);
    ck("rst_ex_entry", 64'(ex_entry), 64'h0);
    ck("rst_cnt", cnt_value, 64'h0);
    ck("rst_cnt_id", 64'(cnt_id), 64'h5a);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1 ck("cnt_3", cnt_value, 64'd3);
    csr_rnum = CRMD;
    #1 ck("re_low", 64'(csr_rdata), 64'h0);
    wr(TCFG, 32'h13, ONES);
    rd(TVAL, 32'h10, "per_tval_load");
    rd(TCFG, 32'h13, "per_tcfg");
    repeat (16) @(negedge clk);
    rd(TVAL, 32'h0, "per_tval_zero");
    rd(ESTAT, 32'h0, "per_no_ti_yet");
    @(negedge clk);
    rd(ESTAT, 32'h800, "per_ti");
    rd(TVAL, 32'h10, "per_reload");
    wr(TICLR, 32'h1, ONES);
    rd(ESTAT, 32'h0, "per_ticlr");
    wr(TCFG, 32'h11, ONES);
    rd(TVAL, 32'h10, "os_tval_load");
    repeat (16) @(negedge clk);
    rd(TVAL, 32'h0, "os_tval_zero");
    rd(ESTAT, 32'h0, "os_no_ti_yet");
    @(negedge clk);
    rd(ESTAT, 32'h800, "os_ti");
    rd(TCFG, 32'h10, "os_en_cleared");
    @(negedge clk);
    rd(TVAL, 32'h0, "os_tval_hold");
    wr(ECFG, 32'h800, ONES);
    ck("int_ie_off", 64'(has_int), 64'h0);
    wr(CRMD, 32'h7, 32'h4);
    rd(CRMD, 32'hc, "xchg_crmd");
    ck("int_timer", 64'(has_int), 64'h1);
    wr(TICLR, 32'h1, ONES);
    rd(ESTAT, 32'h0, "ticlr_estat");
    ck("int_cleared", 64'(has_int), 64'h0);
    rd(TICLR, 32'h0, "ticlr_reads0");
    wr(CRMD, 32'h0, 32'h7);
    rd(CRMD, 32'h8, "crmd_clear");
    csr_we = 1'b1; csr_wnum = CRMD; csr_wdata = 32'h7; csr_wmask = 32'h4;
    wb_ex = 1'b1; wb_ecode = 6'h9; wb_esubcode = 9'h0; wb_pc = 32'h1c00_0100;
    wb_badv_we = 1'b1; wb_vaddr = 32'hdead_bee1;
    @(negedge clk);
    {csr_we, wb_ex, wb_badv_we} = '0;
    csr_wmask = '0;
    rd(CRMD, 32'h8, "ex_crmd");
    rd(PRMD, 32'h0, "ex_prmd");
    rd(ERA, 32'h1c00_0100, "ex_era");
    rd(BADV, 32'hdead_bee1, "ex_badv");
    rd(ESTAT, 32'h0009_0000, "ex_ecode");
    ck("ex_er_entry", 64'(er_entry), 64'h1c00_0100);
    wr(CRMD, 32'h7, 32'h7);
    rd(CRMD, 32'hf, "crmd_plv3_ie");
    csr_we = 1'b1; csr_wnum = ERA; csr_wdata = 32'h1234_5678; csr_wmask = ONES;
    wb_ex = 1'b1; wb_ecode = 6'h3f; wb_esubcode = 9'h1ff; wb_pc = 32'h1c00_0200;
    wb_vaddr = 32'h0bad_0bad;
    @(negedge clk);
    {csr_we, wb_ex} = '0;
    csr_wmask = '0;
    rd(CRMD, 32'h8, "ex2_crmd");
    rd(PRMD, 32'h7, "ex2_prmd");
    rd(ERA, 32'h1c00_0200, "ex2_era_over_write");
    rd(BADV, 32'hdead_bee1, "ex2_badv_kept");
    rd(ESTAT, 32'h7fff_0000, "ex2_ecode_max");
    csr_we = 1'b1; csr_wnum = CRMD; csr_wdata = 32'h0; csr_wmask = 32'h7;
    ertn_flush = 1'b1;
    @(negedge clk);
    {csr_we, ertn_flush} = '0;
    csr_wmask = '0;
    rd(CRMD, 32'hf, "ertn_crmd");
    rd(PRMD, 32'h7, "ertn_prmd");
    wr(PRMD, 32'h2, ONES);
    rd(PRMD, 32'h2, "prmd_wr");
    ertn_flush = 1'b1;
    @(negedge clk);
    ertn_flush = 1'b0;
    rd(CRMD, 32'ha, "ertn2_crmd");
    wr(ECFG, ONES, ONES);
    rd(ECFG, 32'h1bff, "ecfg_mask");
    wr(EENTRY, ONES, ONES);
    rd(EENTRY, 32'hffff_ffc0, "eentry_mask");
    ck("ex_entry", 64'(ex_entry), 64'hffff_ffc0);
    wr(ESTAT, ONES, ONES);
    rd(ESTAT, 32'h7fff_0003, "estat_sw");
    ck("int_sw_ie_off", 64'(has_int), 64'h0);
    wr(CRMD, 32'h4, 32'h4);
    ck("int_sw", 64'(has_int), 64'h1);
    wr(ESTAT, 32'h0, 32'h3);
    rd(ESTAT, 32'h7fff_0000, "estat_sw_clr");
    ck("int_none", 64'(has_int), 64'h0);
    hw_int_in = 8'h81;
    ipi_int_in = 1'b1;
    rd(ESTAT, 32'h7fff_0000, "hw_latency");
    @(negedge clk);
    hw_int_in = 8'h0;
    ipi_int_in = 1'b0;
    rd(ESTAT, 32'h7fff_1204, "hw_sampled");
    ck("int_hw", 64'(has_int), 64'h1);
    @(negedge clk);
    rd(ESTAT, 32'h7fff_0000, "hw_dropped");
    wr(14'h37, 32'ha5a5_a5a5, ONES);
    rd(14'h37, 32'ha5a5_a5a5, "save7");
    rd(14'h38, 32'h0, "save_oob");
    rd(14'h2f, 32'h0, "save_below");
    wr(14'h37, 32'h0, 32'hffff_0000);
    rd(14'h37, 32'h0000_a5a5, "save7_masked");
    wr(14'h30, 32'h1111_1111, ONES);
    rd(14'h30, 32'h1111_1111, "save0");
    rd(14'h37, 32'h0000_a5a5, "save7_kept");
    wr(TID, 32'hcafe_f00d, ONES);
    ck("cnt_id", 64'(cnt_id), 64'hcafe_f00d);
    wr(TCFG, 32'h1, ONES);
    rd(TVAL, 32'h0, "w12_tval0");
    wr(TICLR, 32'h1, ONES);
    rd(ESTAT, 32'h7fff_0800, "w12_set_beats_clr");
    rd(TCFG, 32'h0, "w12_oneshot_off");
    wr(TCFG, ONES & 32'hffff_fff3, ONES);
    rd(TCFG, 32'hff3, "w12_tcfg_zext");
    rd(TVAL, 32'hff0, "w12_tval_zext");
    repeat (2) @(negedge clk);
    rd(TVAL, 32'hfee, "w12_count");
    resetn = 1'b0;
    rd(TVAL, 32'h0, "mid_rst_tval");
    rd(ESTAT, 32'h0, "mid_rst_ti");
    rd(TCFG, 32'h0, "mid_rst_tcfg");
    rd(CRMD, 32'h8, "mid_rst_crmd");
    rd(ECFG, 32'h0, "mid_rst_ecfg");
    ck("mid_rst_has_int", 64'(has_int), 64'h0);
    ck("mid_rst_ex_entry", 64'(ex_entry), 64'h0);
    ck("mid_rst_cnt", cnt_value, 64'h0);
    ck("mid_rst_cnt_id", 64'(cnt_id), 64'h5a);
    rd(14'h37, 32'h0000_a5a5, "save_no_reset");
    rd(ERA, 32'h1c00_0200, "era_no_reset");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    rd(TVAL, 32'h0, "post_rst_stopped");
    ck("post_rst_cnt", cnt_value, 64'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
